// File: rtl/pos_pkg.sv
// Shared definitions for the programmable product-of-sums evaluator.
//   state_e  : sweep FSM states (S_IDLE, S_SWEEP)
//   mask_w() : truth-table width for an n-input function (1 << n)
package pos_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_e;

  function automatic int mask_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/pos_mask_bank.sv
// N_CH maxterm mask registers with a single write port and a combinational
// lookup. A set mask bit forces that channel's output to 0 for the
// corresponding input combination.
//   clk, rst_n   : clock, synchronous active-low reset (masks <- RESET_MASK)
//   wr_en_i      : write strobe (already qualified by the handshake)
//   wr_ch_i      : channel to write; values >= N_CH match no channel
//   wr_mask_i    : new mask
//   rd_idx_i     : combination to evaluate
//   rd_data_o    : bit k = ~mask_k[rd_idx_i]
module pos_mask_bank
  import pos_pkg::*;
#(
  parameter int          N_IN       = 4,
  parameter int          N_CH       = 1,
  parameter logic [63:0] RESET_MASK = 64'h551F,
  localparam int         MASK_W     = mask_w(N_IN),
  localparam int         CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [MASK_W-1:0] wr_mask_i,
  input  logic [N_IN-1:0]   rd_idx_i,
  output logic [N_CH-1:0]   rd_data_o
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [MASK_W-1:0] mask_q;

    // Out-of-range channel numbers never equal any k, so they are dropped.
    always_ff @(posedge clk) begin
      if (!rst_n)
        mask_q <= RESET_MASK[MASK_W-1:0];
      else if (wr_en_i && (wr_ch_i == CH_W'(k)))
        mask_q <= wr_mask_i;
    end

    assign rd_data_o[k] = ~mask_q[rd_idx_i];
  end

endmodule

// File: rtl/pos_prog_eval.sv
// Programmable multi-channel product-of-sums evaluator: valid/ready input
// stream, registered output, optional truth-table sweep engine.
// Build option: define POS_SWEEP_EN to include the sweep FSM and counter;
// otherwise sweep_start is ignored and sweep_busy/out_last are tied 0.
//   clk, rst_n              : clock, synchronous active-low reset
//   cfg_valid/ready/ch/mask : mask write port (blocked during a sweep)
//   in_valid/ready/data     : combination stream (blocked during a sweep)
//   sweep_start, sweep_busy : sweep trigger pulse and status
//   out_valid/ready         : result handshake
//   out_data, out_index     : per-channel result and its combination
//   out_last                : final beat of a sweep
module pos_prog_eval
  import pos_pkg::*;
#(
  parameter int          N_IN       = 4,
  parameter int          N_CH       = 1,
  parameter logic [63:0] RESET_MASK = 64'h551F,
  localparam int         MASK_W     = mask_w(N_IN),
  localparam int         CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [MASK_W-1:0] cfg_mask,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_CH-1:0]   out_data,
  output logic [N_IN-1:0]   out_index,
  output logic              out_last
);

  localparam int CNT_W = N_IN + 1;

  logic              out_valid_q, out_valid_d;
  logic [N_CH-1:0]   out_data_q,  out_data_d;
  logic [N_IN-1:0]   out_index_q, out_index_d;
  logic              free, in_fire, sweep_load, load;
  logic              busy;
  logic [N_IN-1:0]   rd_idx;
  logic [N_CH-1:0]   rd_data;

  // Output register can take a new beat when empty or being drained.
  assign free      = ~out_valid_q | out_ready;
  assign in_ready  = ~busy & free;
  assign cfg_ready = ~busy;
  assign in_fire   = in_valid & in_ready;
  assign load      = in_fire | sweep_load;

  // Lookup reads registered masks, so a same-cycle write is seen only by
  // later inputs.
  pos_mask_bank #(
    .N_IN       (N_IN),
    .N_CH       (N_CH),
    .RESET_MASK (RESET_MASK)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (cfg_valid & cfg_ready),
    .wr_ch_i   (cfg_ch),
    .wr_mask_i (cfg_mask),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

`ifdef POS_SWEEP_EN
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_last_q, out_last_d;
  logic             cnt_at_end;

  assign busy       = (state_q == S_SWEEP);
  assign sweep_load = busy & free;
  assign cnt_at_end = (cnt_q == CNT_W'(MASK_W - 1));
  assign rd_idx     = busy ? cnt_q[N_IN-1:0] : in_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_last_d = out_last_q;
    if (state_q == S_IDLE) begin
      if (sweep_start) begin
        state_d = S_SWEEP;
        cnt_d   = '0;
      end
    end else if (free) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_at_end) state_d = S_IDLE;
    end
    // Stream beats always clear out_last; sweep beats flag the final index.
    if (load) out_last_d = sweep_load & cnt_at_end;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_last = out_last_q;
`else
  logic unused_sweep_start;

  assign unused_sweep_start = sweep_start;
  assign busy               = 1'b0;
  assign sweep_load         = 1'b0;
  assign rd_idx             = in_data;
  assign out_last           = 1'b0;
`endif

  assign sweep_busy = busy;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    if (free) begin
      out_valid_d = load;
      if (load) begin
        out_data_d  = rd_data;
        out_index_d = rd_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;

endmodule

// File: tb/tb_pos_prog_eval.sv
// Directed bench for pos_prog_eval with N_IN=4, N_CH=2. Sweep scenarios
// build only when POS_SWEEP_EN is defined; otherwise the sweep input is
// checked to have no effect.
module tb_pos_prog_eval;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready;
  logic [0:0]  cfg_ch;
  logic [15:0] cfg_mask;
  logic        in_valid, in_ready;
  logic [3:0]  in_data;
  logic        sweep_start, sweep_busy;
  logic        out_valid, out_ready;
  logic [1:0]  out_data;
  logic [3:0]  out_index;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  pos_prog_eval #(.N_IN(4), .N_CH(2), .RESET_MASK(64'h551F)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_mask(cfg_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Hand-derived ones of a 16'h551F mask: maxterms 0,1,2,3,4,8,10,12,14.
  function automatic logic f_rst(input int i);
    return (i == 5) || (i == 6) || (i == 7) || (i == 9) ||
           (i == 11) || (i == 13) || (i == 15);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_mask = '0;
    in_valid = 1'b0; in_data = '0; sweep_start = 1'b0; out_ready = 1'b1;
    step(); step();
    checks++;
    if ({out_valid, out_data, out_index, out_last, sweep_busy} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%b i=%0d l=%b b=%b want all 0",
               out_valid, out_data, out_index, out_last, sweep_busy);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({in_ready, cfg_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready got in_ready=%b cfg_ready=%b want 1 1", in_ready, cfg_ready);
    end
  endtask

  task automatic test_stream_reset_masks();
    logic exp;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      step();
      exp = f_rst(i);
      checks++;
      if (out_valid !== 1'b1 || out_index !== 4'(i) || out_data !== {exp, exp} || out_last !== 1'b0) begin
        errors++;
        $display("FAIL stream_idx%0d got v=%b i=%0d d=%b l=%b want v=1 i=%0d d=%b l=0",
                 i, out_valid, out_index, out_data, out_last, i, {exp, exp});
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_cfg_write();
    logic [3:0] idx [3] = '{4'd0, 4'd3, 4'd9};
    logic [1:0] exp [3] = '{2'b10, 2'b00, 2'b01};
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_mask = 16'hFFFE;
    step();
    cfg_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1; in_data = idx[n];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_index !== idx[n] || out_data !== exp[n]) begin
        errors++;
        $display("FAIL cfg_idx%0d got v=%b i=%0d d=%b want v=1 d=%b",
                 idx[n], out_valid, out_index, out_data, exp[n]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'd7;
    step();
    in_data = 4'd11;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_index !== 4'd7 || out_data !== 2'b01 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cyc%0d got v=%b i=%0d d=%b in_ready=%b want v=1 i=7 d=01 in_ready=0",
                 c, out_valid, out_index, out_data, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got in_ready=%b want 1", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 4'd11 || out_data !== 2'b01) begin
      errors++;
      $display("FAIL release_next got v=%b i=%0d d=%b want v=1 i=11 d=01", out_valid, out_index, out_data);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_nodup got out_valid=%b want 0", out_valid);
    end
  endtask

`ifdef POS_SWEEP_EN
  task automatic test_sweep();
    logic [1:0] exp;
    out_ready = 1'b1; in_valid = 1'b0;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    // Stream input offered throughout the sweep must be held off.
    in_valid = 1'b1; in_data = 4'd3;
    checks++;
    if (sweep_busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL sweep_enter got busy=%b v=%b in_ready=%b cfg_ready=%b want 1 0 0 0",
               sweep_busy, out_valid, in_ready, cfg_ready);
    end
    // ch0 = reset mask, ch1 = 16'hFFFE (only index 0 gives 1).
    for (int j = 0; j < 16; j++) begin
      step();
      exp = {(j == 0), f_rst(j)};
      checks++;
      if (out_valid !== 1'b1 || out_index !== 4'(j) || out_data !== exp ||
          out_last !== (j == 15) || sweep_busy !== (j != 15)) begin
        errors++;
        $display("FAIL sweep_beat%0d got v=%b i=%0d d=%b l=%b b=%b want v=1 i=%0d d=%b l=%b b=%b",
                 j, out_valid, out_index, out_data, out_last, sweep_busy,
                 j, exp, (j == 15), (j != 15));
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 4'd3 || out_data !== 2'b00 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL sweep_after got v=%b i=%0d d=%b l=%b want v=1 i=3 d=00 l=0",
               out_valid, out_index, out_data, out_last);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_sweep();
    out_ready = 1'b1;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int j = 0; j < 8; j++) step();
    checks++;
    if (out_index !== 4'd7 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midsweep_pos got v=%b i=%0d want v=1 i=7", out_valid, out_index);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || sweep_busy !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_reset got v=%b b=%b want 0 0", out_valid, sweep_busy);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || sweep_busy !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_nobeat got v=%b b=%b want 0 0", out_valid, sweep_busy);
    end
    // ch1 back at the reset mask: index 0 -> 00, index 5 -> 11.
    in_valid = 1'b1; in_data = 4'd0;
    step();
    in_data = 4'd5;
    checks++;
    if (out_data !== 2'b00) begin
      errors++;
      $display("FAIL midsweep_mask0 got d=%b want 00", out_data);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'b11) begin
      errors++;
      $display("FAIL midsweep_mask5 got v=%b d=%b want 1 11", out_valid, out_data);
    end
    step();
  endtask
`else
  task automatic test_no_sweep();
    out_ready = 1'b1; in_valid = 1'b0;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_valid !== 1'b0 || sweep_busy !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL nosweep_cyc%0d got v=%b b=%b l=%b in_ready=%b want 0 0 0 1",
                 c, out_valid, sweep_busy, out_last, in_ready);
      end
      step();
    end
  endtask
`endif

  task automatic test_same_cycle_cfg();
    // Masks at reset values here; write ch0 = 0 while accepting index 0.
    out_ready = 1'b1;
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_mask = 16'h0000;
    in_valid = 1'b1; in_data = 4'd0;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'b00) begin
      errors++;
      $display("FAIL samecyc_old got v=%b d=%b want 1 00", out_valid, out_data);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'b01) begin
      errors++;
      $display("FAIL samecyc_new got v=%b d=%b want 1 01", out_valid, out_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_stream_reset_masks();
    test_cfg_write();
    test_backpressure();
`ifdef POS_SWEEP_EN
    test_sweep();
    test_reset_mid_sweep();
`else
    test_no_sweep();
    // Bring masks back to reset values for the same-cycle scenario.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
`endif
    test_same_cycle_cfg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
